// File: rtl/ssm_pkg.sv
// Shared definitions for the execute-phase sequencers: opcodes, fetch
// select codes, ALU controller state encoding and IR field positions.
package ssm_pkg;

    // Register-register ALU opcodes (IR[15:12]); alu_op is the low three bits
    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_NOT  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_XNOR = 4'b0111
    } alu_opcode_e;

    // FSM_start codes issued by the fetch sequencer
    localparam logic [3:0] FSM_ALU   = 4'b0001;
    localparam logic [3:0] FSM_ALU_I = 4'b0010;
    localparam logic [3:0] FSM_MOV   = 4'b0100;
    localparam logic [3:0] FSM_MOVI  = 4'b1000;
    localparam logic [3:0] FSM_STORE = 4'b1001;
    localparam logic [3:0] FSM_JUMP  = 4'b1010;
    localparam logic [3:0] FSM_NONE  = 4'b1111;

    // ALU execute controller state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_RD_A   = 3'd2;
    localparam logic [2:0] ST_RD_B   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    // IR field most-significant bit positions
    localparam int IR_OP_MSB = 15;
    localparam int IR_RD_MSB = 11;
    localparam int IR_RS_MSB = 7;
    localparam int IR_RT_MSB = 3;

    // True for the register-register ALU opcodes 0001..0111
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op != 4'b0000) && (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_exec_controller_if.sv
// Bus bundle between the fetch/datapath side and the ALU execute controller.
interface alu_exec_controller_if #(
    parameter int REG_SEL_W = 4
);
    logic [3:0]           FSM_start;
    logic                 IR_in_en;
    logic [15:0]          IR;
    logic                 alu_zero;
    logic [REG_SEL_W-1:0] reg_out_sel;
    logic                 reg_out_en;
    logic [REG_SEL_W-1:0] reg_in_sel;
    logic                 reg_in_en;
    logic                 A_in_en;
    logic                 G_in_en;
    logic                 G_out_en;
    logic [2:0]           alu_op;
    logic                 Z_flag;
    logic                 DONE;
    logic                 busy;
    logic                 illegal;

    // Fetch sequencer / datapath side
    modport master (
        output FSM_start, IR_in_en, IR, alu_zero,
        input  reg_out_sel, reg_out_en, reg_in_sel, reg_in_en, A_in_en,
               G_in_en, G_out_en, alu_op, Z_flag, DONE, busy, illegal
    );

    // Execute controller side
    modport slave (
        input  FSM_start, IR_in_en, IR, alu_zero,
        output reg_out_sel, reg_out_en, reg_in_sel, reg_in_en, A_in_en,
               G_in_en, G_out_en, alu_op, Z_flag, DONE, busy, illegal
    );
endinterface

// File: rtl/alu_exec_controller.sv
// Execute-phase sequencer for register-register ALU instructions. Runs a
// fixed DECODE/RD_A/RD_B/WB/FIN sequence on the shared bus. Every output is
// a register loaded from the decode of the next state, so each output is
// valid for exactly the cycle its state is occupied and never depends
// combinationally on IR.
import ssm_pkg::*;

module alu_exec_controller #(
    parameter logic [3:0] START_CODE = 4'b0001,
    parameter int         REG_SEL_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_exec_controller_if.slave bus
);

    logic [2:0]           state_r;
    logic [2:0]           state_s;
    logic                 armed_r;
    logic                 accept_s;
    logic                 legal_s;

    logic [3:0]           opcode_r;
    logic [REG_SEL_W-1:0] rd_r;
    logic [REG_SEL_W-1:0] rs_r;
    logic [REG_SEL_W-1:0] rt_r;

    logic [REG_SEL_W-1:0] reg_out_sel_s, reg_out_sel_r;
    logic                 reg_out_en_s,  reg_out_en_r;
    logic [REG_SEL_W-1:0] reg_in_sel_s,  reg_in_sel_r;
    logic                 reg_in_en_s,   reg_in_en_r;
    logic                 a_in_en_s,     a_in_en_r;
    logic                 g_in_en_s,     g_in_en_r;
    logic                 g_out_en_s,    g_out_en_r;
    logic [2:0]           alu_op_s,      alu_op_r;
    logic                 done_s,        done_r;
    logic                 busy_s,        busy_r;
    logic                 z_flag_r;
    logic                 illegal_r;

    // A start is taken only once per IR load, and only from IDLE
    assign accept_s = (state_r == ST_IDLE) && armed_r && (bus.FSM_start == START_CODE);
    assign legal_s  = is_alu_op(opcode_r);

    // Next-state sequencing; unknown encodings fall back to IDLE
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_DECODE;
                else          state_s = ST_IDLE;
            end
            ST_DECODE: begin
                if (legal_s) state_s = ST_RD_A;
                else         state_s = ST_FIN;
            end
            ST_RD_A: state_s = ST_RD_B;
            ST_RD_B: state_s = ST_WB;
            ST_WB:   state_s = ST_FIN;
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode of the state about to be entered
    always_comb begin
        reg_out_sel_s = {REG_SEL_W{1'b0}};
        reg_out_en_s  = 1'b0;
        reg_in_sel_s  = {REG_SEL_W{1'b0}};
        reg_in_en_s   = 1'b0;
        a_in_en_s     = 1'b0;
        g_in_en_s     = 1'b0;
        g_out_en_s    = 1'b0;
        alu_op_s      = 3'b000;
        done_s        = 1'b0;
        busy_s        = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_DECODE: begin
                busy_s = 1'b1;
            end
            ST_RD_A: begin
                busy_s        = 1'b1;
                reg_out_sel_s = rs_r;
                reg_out_en_s  = 1'b1;
                a_in_en_s     = 1'b1;
            end
            ST_RD_B: begin
                busy_s    = 1'b1;
                g_in_en_s = 1'b1;
                alu_op_s  = opcode_r[2:0];
                // NOT is unary: the second operand slot leaves the bus idle
                if (opcode_r != OP_NOT) begin
                    reg_out_sel_s = rt_r;
                    reg_out_en_s  = 1'b1;
                end else begin
                    reg_out_sel_s = {REG_SEL_W{1'b0}};
                    reg_out_en_s  = 1'b0;
                end
            end
            ST_WB: begin
                busy_s       = 1'b1;
                g_out_en_s   = 1'b1;
                reg_in_sel_s = rd_r;
                reg_in_en_s  = 1'b1;
            end
            ST_FIN: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State register and start arming (a new IR load wins over acceptance)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (bus.IR_in_en)  armed_r <= 1'b1;
            else if (accept_s) armed_r <= 1'b0;
            else               armed_r <= armed_r;
        end
    end

    // Instruction fields are captured at acceptance so later IR changes are ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_r <= 4'b0000;
            rd_r     <= {REG_SEL_W{1'b0}};
            rs_r     <= {REG_SEL_W{1'b0}};
            rt_r     <= {REG_SEL_W{1'b0}};
        end else if (accept_s) begin
            opcode_r <= bus.IR[IR_OP_MSB -: 4];
            rd_r     <= bus.IR[IR_RD_MSB -: REG_SEL_W];
            rs_r     <= bus.IR[IR_RS_MSB -: REG_SEL_W];
            rt_r     <= bus.IR[IR_RT_MSB -: REG_SEL_W];
        end else begin
            opcode_r <= opcode_r;
            rd_r     <= rd_r;
            rs_r     <= rs_r;
            rt_r     <= rt_r;
        end
    end

    // Zero flag follows the ALU result of the second-operand cycle only
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_flag_r <= 1'b0;
        end else if (state_r == ST_RD_B) begin
            z_flag_r <= bus.alu_zero;
        end else begin
            z_flag_r <= z_flag_r;
        end
    end

    // Illegal indication: cleared by each accept, set when DECODE rejects the opcode
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_DECODE) && !legal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Registered datapath controls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_out_sel_r <= {REG_SEL_W{1'b0}};
            reg_out_en_r  <= 1'b0;
            reg_in_sel_r  <= {REG_SEL_W{1'b0}};
            reg_in_en_r   <= 1'b0;
            a_in_en_r     <= 1'b0;
            g_in_en_r     <= 1'b0;
            g_out_en_r    <= 1'b0;
            alu_op_r      <= 3'b000;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            reg_out_sel_r <= reg_out_sel_s;
            reg_out_en_r  <= reg_out_en_s;
            reg_in_sel_r  <= reg_in_sel_s;
            reg_in_en_r   <= reg_in_en_s;
            a_in_en_r     <= a_in_en_s;
            g_in_en_r     <= g_in_en_s;
            g_out_en_r    <= g_out_en_s;
            alu_op_r      <= alu_op_s;
            done_r        <= done_s;
            busy_r        <= busy_s;
        end
    end

    assign bus.reg_out_sel = reg_out_sel_r;
    assign bus.reg_out_en  = reg_out_en_r;
    assign bus.reg_in_sel  = reg_in_sel_r;
    assign bus.reg_in_en   = reg_in_en_r;
    assign bus.A_in_en     = a_in_en_r;
    assign bus.G_in_en     = g_in_en_r;
    assign bus.G_out_en    = g_out_en_r;
    assign bus.alu_op      = alu_op_r;
    assign bus.Z_flag      = z_flag_r;
    assign bus.DONE        = done_r;
    assign bus.busy        = busy_r;
    assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_alu_exec_controller.sv
// Scoreboard bench for alu_exec_controller: stimulus pushes the expected
// per-cycle output snapshot of every busy cycle; a monitor pops and compares
// whenever the controller shows busy or DONE.
module tb_alu_exec_controller;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic z_model;

    logic [19:0] exp_q[$];
    string       tag_q[$];

    alu_exec_controller_if #(.REG_SEL_W(4)) bus ();

    alu_exec_controller #(.START_CODE(4'b0001), .REG_SEL_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {out_sel, out_en, in_sel, in_en, A_in, G_in, G_out, alu_op, Z, DONE, busy, illegal}
    function automatic logic [19:0] mk(input logic [3:0] ros, input logic roe,
                                       input logic [3:0] ris, input logic rie,
                                       input logic a, input logic gi, input logic go,
                                       input logic [2:0] op, input logic z,
                                       input logic done, input logic bsy, input logic ill);
        return {ros, roe, ris, rie, a, gi, go, op, z, done, bsy, ill};
    endfunction

    function automatic logic [19:0] snap();
        return {bus.reg_out_sel, bus.reg_out_en, bus.reg_in_sel, bus.reg_in_en,
                bus.A_in_en, bus.G_in_en, bus.G_out_en, bus.alu_op, bus.Z_flag,
                bus.DONE, bus.busy, bus.illegal};
    endfunction

    task automatic push(input logic [19:0] v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    // Expected DECODE, RD_A, RD_B (first n_steps of a legal sequence)
    task automatic push_legal(input logic [15:0] ir, input logic z1, input int n_steps, input string t);
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        op = ir[15:12]; rd = ir[11:8]; rs = ir[7:4]; rt = ir[3:0];
        push(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, z_model, 1'b0, 1'b1, 1'b0), {t, "_decode"});
        if (n_steps > 1)
            push(mk(rs, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, z_model, 1'b0, 1'b1, 1'b0), {t, "_rd_a"});
        if (n_steps > 2) begin
            if (op == 4'b0011)
                push(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, op[2:0], z_model, 1'b0, 1'b1, 1'b0), {t, "_rd_b"});
            else
                push(mk(rt, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, op[2:0], z_model, 1'b0, 1'b1, 1'b0), {t, "_rd_b"});
        end
        if (n_steps > 3) begin
            push(mk(4'h0, 1'b0, rd, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, z1, 1'b0, 1'b1, 1'b0), {t, "_wb"});
            push(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, z1, 1'b1, 1'b1, 1'b0), {t, "_fin"});
            z_model = z1;
        end
    endtask

    task automatic push_illegal(input string t);
        push(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, z_model, 1'b0, 1'b1, 1'b0), {t, "_decode"});
        push(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, z_model, 1'b1, 1'b1, 1'b1), {t, "_fin"});
    endtask

    // Load IR, let the controller accept on the following edge, then scramble IR
    task automatic issue(input logic [15:0] ir);
        @(posedge clock); #1;
        bus.IR       = ir;
        bus.IR_in_en = 1'b1;
        @(posedge clock); #1;
        bus.IR_in_en = 1'b0;
        @(posedge clock); #1;   // accept edge
        bus.IR = 16'hFFFF;
    endtask

    task automatic check_idle(input int n, input string t);
        repeat (n) begin
            @(posedge clock); #1;
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s: busy=%b, required 0", t, bus.busy);
            end
        end
    endtask

    // Monitor: bus exclusivity every cycle, scoreboard pop on every busy/DONE cycle
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (bus.reg_out_en && bus.G_out_en) begin
                errors++;
                $display("FAIL bus_exclusive: reg_out_en=1 G_out_en=1, required not both");
            end
            if (bus.busy || bus.DONE) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_activity: got %h, required idle", snap());
                end else begin
                    logic [19:0] e;
                    string       t;
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (snap() !== e) begin
                        errors++;
                        $display("FAIL %s: got %h, required %h", t, snap(), e);
                    end
                end
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        z_model      = 1'b0;
        reset        = 1'b1;
        bus.FSM_start = 4'b1111;
        bus.IR_in_en = 1'b0;
        bus.IR       = 16'h0000;
        bus.alu_zero = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (snap() !== 20'h00000) begin
            errors++;
            $display("FAIL reset_state: got %h, required 00000", snap());
        end
        reset = 1'b0;

        // FSM_start parked on ALU for the rest of the run; only IR_in_en arms
        bus.FSM_start = 4'b0001;
        check_idle(4, "no_arm_after_reset");

        push_legal(16'h1312, 1'b0, 5, "add");
        issue(16'h1312);
        repeat (6) @(posedge clock);

        push_legal(16'h3450, 1'b0, 5, "not");
        issue(16'h3450);
        repeat (6) @(posedge clock);

        check_idle(10, "held_start_idle");

        push_legal(16'h7ABC, 1'b0, 5, "xnor");
        issue(16'h7ABC);
        repeat (6) @(posedge clock);

        push_illegal("illegal_c");
        issue(16'hC123);
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: got %b, required 1", bus.illegal);
        end

        bus.alu_zero = 1'b1;
        push_legal(16'h2111, 1'b1, 5, "sub_zero");
        issue(16'h2111);
        repeat (6) @(posedge clock);
        bus.alu_zero = 1'b0;

        push_illegal("illegal_0");
        issue(16'h0234);
        repeat (3) @(posedge clock);

        push_legal(16'h1567, 1'b0, 5, "add_clear_z");
        issue(16'h1567);
        repeat (6) @(posedge clock);

        // Reset in the middle of RD_B
        push_legal(16'h69AB, 1'b0, 3, "xor_reset");
        issue(16'h69AB);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (snap() !== {19'h00000, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h, required 00000", snap());
        end
        z_model = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle(10, "no_start_after_reset");

        push_legal(16'h4678, 1'b0, 5, "and_recover");
        issue(16'h4678);
        repeat (6) @(posedge clock);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
